// File: rtl/wb_timer_pkg.sv
// ----------------------------------------------------------------------------
// wb_timer_pkg
// Shared constants and helpers for the Wishbone timer: bus widths, base
// address, register offsets, CTRL/STATUS bit indices and the byte-lane merge
// used for every writable register.
// Optional feature macro: WB_TIMER_PRESCALER_EN (see wb_timer.sv).
// ----------------------------------------------------------------------------
package wb_timer_pkg;

   // Bus geometry
   localparam int unsigned ADR_W  = 32'd24;
   localparam int unsigned DATA_W = 32'd16;
   localparam int unsigned SEL_W  = 32'd2;

   // Word base address of the register block; the low three bits select the register
   localparam logic [ADR_W-1:0] BASE_ADDR = 24'hFF0000;

   // CTRL register layout
   localparam int unsigned CTRL_W           = 32'd3;
   localparam int unsigned CTRL_EN          = 32'd0;
   localparam int unsigned CTRL_AUTO_RELOAD = 32'd1;
   localparam int unsigned CTRL_IRQ_EN      = 32'd2;

   // STATUS register layout
   localparam int unsigned STATUS_MATCH = 32'd0;

   // Register offsets within the block
   typedef enum logic [2:0] {
      OFF_CTRL     = 3'd0,
      OFF_STATUS   = 3'd1,
      OFF_COUNT    = 3'd2,
      OFF_COMPARE  = 3'd3,
      OFF_PRESCALE = 3'd4,
      OFF_RSVD5    = 3'd5,
      OFF_RSVD6    = 3'd6,
      OFF_RSVD7    = 3'd7
   } reg_off_e;

   // Replace only the byte lanes enabled in sel
   function automatic logic [DATA_W-1:0] merge_lanes(
      input logic [DATA_W-1:0] old_v,
      input logic [DATA_W-1:0] new_v,
      input logic [SEL_W-1:0]  sel
   );
      return {sel[1] ? new_v[15:8] : old_v[15:8],
              sel[0] ? new_v[7:0]  : old_v[7:0]};
   endfunction

endpackage

// File: rtl/wb_timer_if.sv
// ----------------------------------------------------------------------------
// wb_timer_if
// Wishbone classic slave bundle for the timer.
//   master modport: drives cyc/stb/we/adr/i_dat/sel, receives o_dat/ack/err/rty
//   slave  modport: the reverse
// ----------------------------------------------------------------------------
interface wb_timer_if;
   import wb_timer_pkg::*;

   logic              wb_cyc;
   logic              wb_stb;
   logic              wb_we;
   logic [ADR_W-1:0]  wb_adr;
   logic [DATA_W-1:0] wb_i_dat;
   logic [SEL_W-1:0]  wb_sel;
   logic [DATA_W-1:0] wb_o_dat;
   logic              wb_ack;
   logic              wb_err;
   logic              wb_rty;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat, wb_sel,
      input  wb_o_dat, wb_ack, wb_err, wb_rty
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat, wb_sel,
      output wb_o_dat, wb_ack, wb_err, wb_rty
   );

endinterface

// File: rtl/wb_timer_prescaler.sv
// ----------------------------------------------------------------------------
// wb_timer_prescaler
// Divides the clock into timer ticks. A tick fires when enabled and the
// internal counter equals the programmed PRESCALE value; the counter then
// restarts at 0. Disabled, or on a write to PRESCALE, the counter is held/
// cleared to 0.
// Ports: i_clk, i_rst (async, active-high), en_i, clr_i, prescale_i[15:0],
//        tick_o.
// Only compiled when WB_TIMER_PRESCALER_EN is defined.
// ----------------------------------------------------------------------------
`ifdef WB_TIMER_PRESCALER_EN
module wb_timer_prescaler
   import wb_timer_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              en_i,
   input  logic              clr_i,
   input  logic [DATA_W-1:0] prescale_i,
   output logic              tick_o
);

   logic [DATA_W-1:0] cnt_q;
   logic [DATA_W-1:0] cnt_d;
   logic              tick_s;

   // Tick detection and next prescale count
   always_comb begin
      tick_s = en_i & (cnt_q == prescale_i);
      if (!en_i || clr_i || tick_s) begin
         cnt_d = 16'd0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Prescale counter state
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = tick_s;

endmodule
`endif

// File: rtl/wb_timer.sv
// ----------------------------------------------------------------------------
// wb_timer
// 16-bit compare timer behind a Wishbone classic slave port.
//   i_clk  : sole clock, rising edge
//   i_rst  : asynchronous active-high reset
//   wb     : wb_timer_if.slave (cyc, stb, we, adr[23:0], i_dat[15:0], sel[1:0],
//            o_dat[15:0], ack, err, rty)
//   o_irq  : level interrupt, MATCH & IRQ_EN
// Registers (word offset): 0 CTRL {IRQ_EN, AUTO_RELOAD, EN}, 1 STATUS {MATCH}
// (write-1-to-clear), 2 COUNT, 3 COMPARE, 4 PRESCALE (only with macro).
// Macro WB_TIMER_PRESCALER_EN: when defined, a PRESCALE register and the
// wb_timer_prescaler sub-module divide the tick rate; when undefined the
// timer ticks every enabled cycle and offset 4 terminates with wb_err.
// ----------------------------------------------------------------------------
module wb_timer
   import wb_timer_pkg::*;
(
   input  logic      i_clk,
   input  logic      i_rst,
   wb_timer_if.slave wb,
   output logic      o_irq
);

   // Bus decode
   logic              sel_s;
   logic              req_s;
   logic              mapped_s;
   logic              wr_s;
   reg_off_e          off_s;
   logic [DATA_W-1:0] rd_s;
   logic              wr_ctrl_s;
   logic              wr_status_s;
   logic              wr_count_s;
   logic              wr_compare_s;

   // Timer core
   logic              tick_s;
   logic              match_hit_s;

   logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
   logic              match_q,   match_d;
   logic [DATA_W-1:0] count_q,   count_d;
   logic [DATA_W-1:0] compare_q, compare_d;
   logic              ack_q,     ack_d;
   logic              err_q,     err_d;
   logic [DATA_W-1:0] dat_q,     dat_d;
   logic              irq_q,     irq_d;

`ifdef WB_TIMER_PRESCALER_EN
   logic [DATA_W-1:0] prescale_q, prescale_d;
   logic              wr_prescale_s;
`endif

   // Address decode, read mux and per-register write strobes
   always_comb begin
      sel_s = wb.wb_cyc & wb.wb_stb &
              (wb.wb_adr[ADR_W-1:3] == BASE_ADDR[ADR_W-1:3]);
      // A termination in flight blocks a new one, so a held strobe is
      // answered every other cycle.
      req_s = sel_s & ~ack_q & ~err_q;
      off_s = reg_off_e'(wb.wb_adr[2:0]);
      case (off_s)
         OFF_CTRL: begin
            mapped_s = 1'b1;
            rd_s     = {13'd0, ctrl_q};
         end
         OFF_STATUS: begin
            mapped_s = 1'b1;
            rd_s     = {15'd0, match_q};
         end
         OFF_COUNT: begin
            mapped_s = 1'b1;
            rd_s     = count_q;
         end
         OFF_COMPARE: begin
            mapped_s = 1'b1;
            rd_s     = compare_q;
         end
         OFF_PRESCALE: begin
`ifdef WB_TIMER_PRESCALER_EN
            mapped_s = 1'b1;
            rd_s     = prescale_q;
`else
            mapped_s = 1'b0;
            rd_s     = 16'd0;
`endif
         end
         default: begin
            mapped_s = 1'b0;
            rd_s     = 16'd0;
         end
      endcase
      wr_s         = req_s & wb.wb_we & mapped_s;
      wr_ctrl_s    = wr_s & (off_s == OFF_CTRL);
      wr_status_s  = wr_s & (off_s == OFF_STATUS);
      wr_count_s   = wr_s & (off_s == OFF_COUNT);
      wr_compare_s = wr_s & (off_s == OFF_COMPARE);
`ifdef WB_TIMER_PRESCALER_EN
      wr_prescale_s = wr_s & (off_s == OFF_PRESCALE);
`endif
   end

`ifdef WB_TIMER_PRESCALER_EN
   wb_timer_prescaler u_prescaler (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .en_i       (ctrl_q[CTRL_EN]),
      .clr_i      (wr_prescale_s),
      .prescale_i (prescale_q),
      .tick_o     (tick_s)
   );
`else
   assign tick_s = ctrl_q[CTRL_EN];
`endif

   // Timer core and register next state; bus writes take priority over ticks
   always_comb begin
      match_hit_s = tick_s & (count_q == compare_q);

      if (wr_ctrl_s && wb.wb_sel[0]) begin
         ctrl_d = wb.wb_i_dat[CTRL_W-1:0];
      end else begin
         ctrl_d = ctrl_q;
      end

      if (wr_compare_s) begin
         compare_d = merge_lanes(compare_q, wb.wb_i_dat, wb.wb_sel);
      end else begin
         compare_d = compare_q;
      end

      if (wr_count_s) begin
         count_d = merge_lanes(count_q, wb.wb_i_dat, wb.wb_sel);
      end else if (match_hit_s && ctrl_q[CTRL_AUTO_RELOAD]) begin
         count_d = 16'd0;
      end else if (tick_s) begin
         count_d = count_q + 16'd1;
      end else begin
         count_d = count_q;
      end

      // A fresh match beats a simultaneous clear
      if (match_hit_s) begin
         match_d = 1'b1;
      end else if (wr_status_s && wb.wb_sel[0] && wb.wb_i_dat[STATUS_MATCH]) begin
         match_d = 1'b0;
      end else begin
         match_d = match_q;
      end

`ifdef WB_TIMER_PRESCALER_EN
      if (wr_prescale_s) begin
         prescale_d = merge_lanes(prescale_q, wb.wb_i_dat, wb.wb_sel);
      end else begin
         prescale_d = prescale_q;
      end
`endif

      irq_d = match_d & ctrl_d[CTRL_IRQ_EN];
      ack_d = req_s & mapped_s;
      err_d = req_s & ~mapped_s;
      if (req_s && mapped_s && !wb.wb_we) begin
         dat_d = rd_s;
      end else begin
         dat_d = 16'd0;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ctrl_q     <= 3'd0;
         match_q    <= 1'b0;
         count_q    <= 16'd0;
         compare_q  <= 16'd0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         dat_q      <= 16'd0;
         irq_q      <= 1'b0;
`ifdef WB_TIMER_PRESCALER_EN
         prescale_q <= 16'd0;
`endif
      end else begin
         ctrl_q     <= ctrl_d;
         match_q    <= match_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         dat_q      <= dat_d;
         irq_q      <= irq_d;
`ifdef WB_TIMER_PRESCALER_EN
         prescale_q <= prescale_d;
`endif
      end
   end

   assign wb.wb_o_dat = dat_q;
   assign wb.wb_ack   = ack_q;
   assign wb.wb_err   = err_q;
   assign wb.wb_rty   = 1'b0;
   assign o_irq       = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// ----------------------------------------------------------------------------
// tb_wb_timer
// Directed self-checking bench for wb_timer. Inputs change on the falling
// edge; outputs are sampled 1 ns after the rising edge or on the falling edge.
// Works with WB_TIMER_PRESCALER_EN either defined or undefined.
// ----------------------------------------------------------------------------
module tb_wb_timer;

   localparam logic [23:0] BASE = 24'hFF0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic irq;
   int   n_checks = 0;
   int   n_fail   = 0;

   wb_timer_if bus ();

   wb_timer dut (
      .i_clk (clk),
      .i_rst (rst),
      .wb    (bus),
      .o_irq (irq)
   );

   always #5 clk = ~clk;

   // Hard stop in case something wedges the stimulus
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic bus_idle();
      bus.wb_cyc   = 1'b0;
      bus.wb_stb   = 1'b0;
      bus.wb_we    = 1'b0;
      bus.wb_adr   = 24'd0;
      bus.wb_i_dat = 16'd0;
      bus.wb_sel   = 2'b00;
   endtask

   task automatic bus_drive(input logic we, input logic [23:0] adr,
                            input logic [15:0] d, input logic [1:0] sel);
      bus.wb_cyc   = 1'b1;
      bus.wb_stb   = 1'b1;
      bus.wb_we    = we;
      bus.wb_adr   = adr;
      bus.wb_i_dat = d;
      bus.wb_sel   = sel;
   endtask

   // One single-beat transfer; returns what the slave showed after the first edge.
   task automatic xfer(input logic we, input logic [23:0] adr, input logic [15:0] d,
                       input logic [1:0] sel, output logic a, output logic e,
                       output logic [15:0] r);
      @(negedge clk);
      bus_drive(we, adr, d, sel);
      @(posedge clk);
      #1;
      a = bus.wb_ack;
      e = bus.wb_err;
      r = bus.wb_o_dat;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic wr(input logic [2:0] off, input logic [15:0] d, input logic [1:0] sel);
      logic a, e;
      logic [15:0] r;
      xfer(1'b1, BASE + {21'd0, off}, d, sel, a, e, r);
   endtask

   task automatic rd(input logic [2:0] off, output logic [15:0] data);
      logic a, e;
      xfer(1'b0, BASE + {21'd0, off}, 16'd0, 2'b11, a, e, data);
   endtask

   task automatic test_reset();
      logic [15:0] r;
      #1 rst = 1'b1;
      #2;
      n_checks++; if (bus.wb_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", bus.wb_ack); end
      n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.wb_err); end
      n_checks++; if (bus.wb_o_dat !== 16'h0000) begin n_fail++; $display("FAIL rst_dat: got %h want 0000", bus.wb_o_dat); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq); end
      n_checks++; if (bus.wb_rty !== 1'b0) begin n_fail++; $display("FAIL rst_rty: got %b want 0", bus.wb_rty); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rd(3'd0, r);
      n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL rst_ctrl: got %h want 0000", r); end
      rd(3'd2, r);
      n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL rst_count: got %h want 0000", r); end
      rd(3'd1, r);
      n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL rst_status: got %h want 0000", r); end
   endtask

   task automatic test_basic();
      logic a, e;
      logic [15:0] r;
      @(negedge clk);
      bus_drive(1'b1, BASE, 16'h0001, 2'b11);
      #1;
      n_checks++; if (bus.wb_ack !== 1'b0) begin n_fail++; $display("FAIL basic_early_ack: got %b want 0", bus.wb_ack); end
      @(posedge clk);
      #1;
      n_checks++; if (bus.wb_ack !== 1'b1) begin n_fail++; $display("FAIL basic_wr_ack: got %b want 1", bus.wb_ack); end
      n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL basic_wr_err: got %b want 0", bus.wb_err); end
      n_checks++; if (bus.wb_rty !== 1'b0) begin n_fail++; $display("FAIL basic_wr_rty: got %b want 0", bus.wb_rty); end
      @(negedge clk);
      bus_idle();
      @(posedge clk);
      #1;
      n_checks++; if (bus.wb_ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_width: got %b want 0", bus.wb_ack); end
      xfer(1'b0, BASE, 16'd0, 2'b11, a, e, r);
      n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL basic_rd_ack: got %b want 1", a); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_rd_err: got %b want 0", e); end
      n_checks++; if (r !== 16'h0001) begin n_fail++; $display("FAIL basic_rd_data: got %h want 0001", r); end
      wr(3'd0, 16'h0000, 2'b11);
   endtask

   task automatic test_back_to_back();
      logic       exp_ack;
      logic [15:0] exp_dat;
      wr(3'd0, 16'h0006, 2'b11);
      @(negedge clk);
      bus_drive(1'b0, BASE, 16'd0, 2'b11);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         exp_ack = (i % 2 == 0);
         exp_dat = exp_ack ? 16'h0006 : 16'h0000;
         n_checks++; if (bus.wb_ack !== exp_ack) begin n_fail++; $display("FAIL b2b_ack[%0d]: got %b want %b", i, bus.wb_ack, exp_ack); end
         n_checks++; if (bus.wb_o_dat !== exp_dat) begin n_fail++; $display("FAIL b2b_dat[%0d]: got %h want %h", i, bus.wb_o_dat, exp_dat); end
      end
      @(negedge clk);
      bus_idle();
      wr(3'd0, 16'h0000, 2'b11);
   endtask

   task automatic test_unmapped();
      logic a, e;
      logic [15:0] r;
      wr(3'd0, 16'h0002, 2'b11);
      wr(3'd3, 16'h1234, 2'b11);
      wr(3'd2, 16'h0777, 2'b11);
      wr(3'd1, 16'h0001, 2'b11);
      xfer(1'b0, BASE + 24'd6, 16'd0, 2'b11, a, e, r);
      n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL unmap_rd6_err: got %b want 1", e); end
      n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL unmap_rd6_ack: got %b want 0", a); end
      n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL unmap_rd6_dat: got %h want 0000", r); end
      @(posedge clk);
      #1;
      n_checks++; if (bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL unmap_err_width: got %b want 0", bus.wb_err); end
      for (int i = 5; i < 8; i++) begin
         xfer(1'b1, BASE + i, 16'hFFFF, 2'b11, a, e, r);
         n_checks++; if (e !== 1'b1 || a !== 1'b0) begin n_fail++; $display("FAIL unmap_wr%0d: got err=%b ack=%b want err=1 ack=0", i, e, a); end
      end
`ifndef WB_TIMER_PRESCALER_EN
      xfer(1'b1, BASE + 24'd4, 16'hFFFF, 2'b11, a, e, r);
      n_checks++; if (e !== 1'b1 || a !== 1'b0) begin n_fail++; $display("FAIL unmap_wr4: got err=%b ack=%b want err=1 ack=0", e, a); end
      xfer(1'b0, BASE + 24'd4, 16'd0, 2'b11, a, e, r);
      n_checks++; if (e !== 1'b1 || a !== 1'b0) begin n_fail++; $display("FAIL unmap_rd4: got err=%b ack=%b want err=1 ack=0", e, a); end
`endif
      // Neighbouring block address: no response at all
      xfer(1'b1, 24'hFF0008, 16'hFFFF, 2'b11, a, e, r);
      n_checks++; if (a !== 1'b0 || e !== 1'b0) begin n_fail++; $display("FAIL unsel_wr: got ack=%b err=%b want 0 0", a, e); end
      xfer(1'b0, 24'hFE0003, 16'd0, 2'b11, a, e, r);
      n_checks++; if (a !== 1'b0 || e !== 1'b0) begin n_fail++; $display("FAIL unsel_rd: got ack=%b err=%b want 0 0", a, e); end
      rd(3'd0, r);
      n_checks++; if (r !== 16'h0002) begin n_fail++; $display("FAIL unmap_keep_ctrl: got %h want 0002", r); end
      rd(3'd3, r);
      n_checks++; if (r !== 16'h1234) begin n_fail++; $display("FAIL unmap_keep_cmp: got %h want 1234", r); end
      rd(3'd2, r);
      n_checks++; if (r !== 16'h0777) begin n_fail++; $display("FAIL unmap_keep_count: got %h want 0777", r); end
      rd(3'd1, r);
      n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL unmap_keep_status: got %h want 0000", r); end
   endtask

   task automatic test_lanes();
      logic [15:0] r;
      wr(3'd0, 16'h0000, 2'b11);
      wr(3'd2, 16'h1200, 2'b11);
      wr(3'd2, 16'hABCD, 2'b01);
      rd(3'd2, r);
      n_checks++; if (r !== 16'h12CD) begin n_fail++; $display("FAIL lane_lo: got %h want 12CD", r); end
      wr(3'd2, 16'h5600, 2'b10);
      rd(3'd2, r);
      n_checks++; if (r !== 16'h56CD) begin n_fail++; $display("FAIL lane_hi: got %h want 56CD", r); end
      wr(3'd2, 16'hFFFF, 2'b00);
      rd(3'd2, r);
      n_checks++; if (r !== 16'h56CD) begin n_fail++; $display("FAIL lane_none: got %h want 56CD", r); end
   endtask

   task automatic test_timer_run();
      logic [15:0] r;
      int cyc;
`ifdef WB_TIMER_PRESCALER_EN
      int exp_cyc = 12;
      logic [15:0] exp_count = 16'h0000;
      wr(3'd4, 16'h0002, 2'b11);
      rd(3'd4, r);
      n_checks++; if (r !== 16'h0002) begin n_fail++; $display("FAIL run_prescale_rd: got %h want 0002", r); end
`else
      int exp_cyc = 4;
      logic [15:0] exp_count = 16'h0001;
`endif
      wr(3'd3, 16'h0003, 2'b11);
      wr(3'd2, 16'h0000, 2'b11);
      wr(3'd1, 16'h0001, 2'b11);
      wr(3'd0, 16'h0007, 2'b11);
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (irq === 1'b1) break;
      end
      n_checks++; if (cyc !== exp_cyc) begin n_fail++; $display("FAIL run_match_cycle: got %0d want %0d", cyc, exp_cyc); end
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL run_irq: got %b want 1", irq); end
      wr(3'd0, 16'h0004, 2'b11);
      rd(3'd2, r);
      n_checks++; if (r !== exp_count) begin n_fail++; $display("FAIL run_count: got %h want %h", r, exp_count); end
      rd(3'd1, r);
      n_checks++; if (r !== 16'h0001) begin n_fail++; $display("FAIL run_status: got %h want 0001", r); end
      wr(3'd1, 16'h0001, 2'b11);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL run_w1c_irq: got %b want 0", irq); end
      rd(3'd1, r);
      n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL run_w1c_status: got %h want 0000", r); end
   endtask

   task automatic test_edges();
      logic [15:0] r;
`ifdef WB_TIMER_PRESCALER_EN
      wr(3'd4, 16'h0000, 2'b11);
`endif
      // Wrap: 0xFFFF -> 0x0000 (no match) -> match, COUNT 0x0001
      wr(3'd0, 16'h0000, 2'b11);
      wr(3'd2, 16'hFFFF, 2'b11);
      wr(3'd3, 16'h0000, 2'b11);
      wr(3'd1, 16'h0001, 2'b11);
      wr(3'd0, 16'h0005, 2'b11);
      @(negedge clk);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL wrap_first_tick_irq: got %b want 0", irq); end
      bus_drive(1'b1, BASE, 16'h0004, 2'b11);
      @(posedge clk);
      #1;
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL wrap_second_tick_irq: got %b want 1", irq); end
      @(negedge clk);
      bus_idle();
      rd(3'd2, r);
      n_checks++; if (r !== 16'h0001) begin n_fail++; $display("FAIL wrap_count: got %h want 0001", r); end
      rd(3'd1, r);
      n_checks++; if (r !== 16'h0001) begin n_fail++; $display("FAIL wrap_status: got %h want 0001", r); end
      // Bus write to COUNT on a tick edge: written value is what the next tick sees
      wr(3'd1, 16'h0001, 2'b11);
      wr(3'd2, 16'h0000, 2'b11);
      wr(3'd3, 16'h5555, 2'b11);
      wr(3'd0, 16'h0005, 2'b11);
      wr(3'd2, 16'h5555, 2'b11);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL coincide_pre_irq: got %b want 0", irq); end
      @(posedge clk);
      #1;
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL coincide_match_irq: got %b want 1", irq); end
      wr(3'd0, 16'h0000, 2'b11);
      rd(3'd2, r);
      n_checks++; if (r !== 16'h5557) begin n_fail++; $display("FAIL coincide_count: got %h want 5557", r); end
   endtask

   task automatic test_reset_mid();
      logic a, e;
      logic [15:0] r;
      wr(3'd0, 16'h0004, 2'b11);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_irq: got %b want 1", irq); end
      // Reset between strobe and ack
      @(negedge clk);
      bus_drive(1'b0, BASE, 16'd0, 2'b11);
      #2 rst = 1'b1;
      #1;
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rmid_irq: got %b want 0", irq); end
      n_checks++; if (bus.wb_ack !== 1'b0 || bus.wb_err !== 1'b0) begin n_fail++; $display("FAIL rmid_term: got ack=%b err=%b want 0 0", bus.wb_ack, bus.wb_err); end
      @(posedge clk);
      #1;
      n_checks++; if (bus.wb_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_no_ack: got %b want 0", bus.wb_ack); end
      @(negedge clk);
      bus_idle();
      rst = 1'b0;
      // Reset during the ack cycle clears ack and data without a clock
      wr(3'd0, 16'h0002, 2'b11);
      @(negedge clk);
      bus_drive(1'b0, BASE, 16'd0, 2'b11);
      @(posedge clk);
      #1;
      n_checks++; if (bus.wb_ack !== 1'b1 || bus.wb_o_dat !== 16'h0002) begin n_fail++; $display("FAIL rack_pre: got ack=%b dat=%h want 1 0002", bus.wb_ack, bus.wb_o_dat); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (bus.wb_ack !== 1'b0 || bus.wb_o_dat !== 16'h0000) begin n_fail++; $display("FAIL rack_async: got ack=%b dat=%h want 0 0000", bus.wb_ack, bus.wb_o_dat); end
      @(negedge clk);
      bus_idle();
      rst = 1'b0;
      xfer(1'b0, BASE, 16'd0, 2'b11, a, e, r);
      n_checks++; if (a !== 1'b1 || e !== 1'b0 || r !== 16'h0000) begin n_fail++; $display("FAIL rpost_ctrl: got ack=%b err=%b dat=%h want 1 0 0000", a, e, r); end
      rd(3'd1, r);
      n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL rpost_status: got %h want 0000", r); end
   endtask

   initial begin
      bus_idle();
      test_reset();
      test_basic();
      test_back_to_back();
      test_unmapped();
      test_lanes();
      test_timer_run();
      test_edges();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
